cdb_reservation_station: RTL and testbench
==========================================

CDB_RESERVATION_STATION -- requirements
Module: cdb_reservation_station

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter TAG_WIDTH, default 3, meaning ROB tag width (identical to the CDB tag width).
REQ-003 SHALL have parameter DEPTH, default 4, meaning number of entries.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: flush  in  1  discard all entries.
REQ-006 SHALL have dispatch ports: disp_valid in 1; disp_ready out 1; disp_op in 6; disp_tag in TAG_WIDTH (destination ROB tag); disp_dest_reg in 5.
REQ-007 SHALL have, for each source n = 1, 2: disp_srcn_ready in 1; disp_srcn_value in DATA_WIDTH; disp_srcn_tag in TAG_WIDTH (producer tag, used when not ready).
REQ-008 SHALL have CDB snoop ports: cdb_valid in 1; cdb_value in DATA_WIDTH; cdb_tag in TAG_WIDTH.
REQ-009 SHALL have issue ports: issue_valid out 1; issue_ready in 1; issue_op out 6; issue_tag out TAG_WIDTH; issue_dest_reg out 5; issue_src1 out DATA_WIDTH; issue_src2 out DATA_WIDTH.
REQ-010 SHALL have port free_count out clog2(DEPTH+1): number of unoccupied entries.

Function
REQ-011 Each entry SHALL hold: busy, op, tag, dest_reg, and per source a ready bit, a value, and a producer tag.
REQ-012 disp_ready SHALL be 1 iff at least one entry is not busy in the current registered state; entries freed in the same cycle SHALL NOT count.
REQ-013 On disp_valid && disp_ready, the lowest-index non-busy entry SHALL be written at the clock edge and set busy.
REQ-014 Dispatch bypass: a source with disp_srcn_ready=0 SHALL be stored ready, with value cdb_value, when cdb_valid=1 and cdb_tag equals disp_srcn_tag in the same cycle.
REQ-015 Wakeup: every busy entry with a not-ready source whose producer tag equals cdb_tag while cdb_valid=1 SHALL capture cdb_value and set that source ready at the edge; both sources of one entry MAY wake in the same cycle.
REQ-016 An entry SHALL be issuable iff it is busy and both sources are ready in registered state; issue latency SHALL be at least 1 cycle after dispatch or wakeup, never combinational from the CDB.
REQ-017 issue_valid SHALL be 1 iff any entry is issuable; issue_* SHALL reflect the selected entry combinationally; the outputs SHALL be 0 when issue_valid=0.
REQ-018 On issue_valid && issue_ready, the selected entry SHALL clear busy at the edge; the outputs SHALL hold stable while issue_valid=1 and issue_ready=0, unless an older entry becomes issuable (REQ-025).
REQ-019 Issue and dispatch in the same cycle SHALL both take effect; dispatch SHALL NOT target the entry being issued.
REQ-020 flush=1 SHALL clear all busy bits at the edge and take priority over dispatch and wakeup; disp_ready and issue_valid SHALL remain combinationally derived from the pre-edge state.
REQ-021 free_count SHALL equal DEPTH minus the number of busy entries, from registered state.
REQ-022 cdb_valid=0 SHALL cause no state change beyond dispatch, issue, and flush.

Reset
REQ-023 rst=1 SHALL asynchronously clear every busy bit, source ready bit, stored field, and age state; after reset disp_ready=1, issue_valid=0, free_count=DEPTH, and all issue_* outputs are 0.
REQ-024 Deasserting rst mid-operation SHALL leave the block empty; no entry survives reset.

Configuration
REQ-025 Macro RS_AGE_ORDER_EN defined: issue SHALL select the oldest issuable entry by dispatch order, with the age state updated on dispatch, issue, and flush. Macro undefined: issue SHALL select the lowest-index issuable entry and no age state SHALL exist.

Verification
REQ-026 After reset, dispatch op=5, tag=2, both sources ready (0x10, 0x20) -> issue_valid=1 next cycle, issue_src1=0x10, issue_src2=0x20, issue_tag=2; with issue_ready=1 -> free_count returns to 4.
REQ-027 Dispatch with src1 waiting on tag 3; one cycle later cdb_valid=1, cdb_tag=3, cdb_value=0xDEAD -> issue_valid stays 0 that cycle, rises next cycle, issue_src1=0xDEAD.
REQ-028 Dispatch with src2 tag=6 not ready while cdb_valid=1, cdb_tag=6, cdb_value=0x77 in the same cycle -> entry stored ready, issue_valid=1 next cycle, issue_src2=0x77.
REQ-029 Four dispatches, none ready -> disp_ready=0 and free_count=0; a fifth disp_valid is ignored; one CDB wakeup plus issue frees one entry -> disp_ready=1 the following cycle.
REQ-030 RS_AGE_ORDER_EN defined: dispatch A into entry 0, B into entry 1, issue A, dispatch C into entry 0, then wake B and C in the same cycle -> B issues first; with the macro undefined -> C issues first.
REQ-031 Three busy entries and flush=1 with a simultaneous disp_valid -> next cycle free_count=4, issue_valid=0, and the dispatched instruction is not present.

Source files
------------

// File: rtl/cdb_reservation_station_if.sv
// rtl/cdb_reservation_station_if.sv - dispatch, CDB snoop, issue and status bundle
// master drives dispatch/CDB/flush/issue_ready; slave is the reservation station.
interface cdb_reservation_station_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush;

  logic                  disp_valid;
  logic                  disp_ready;
  logic [5:0]            disp_op;
  logic [TAG_WIDTH-1:0]  disp_tag;
  logic [4:0]            disp_dest_reg;
  logic                  disp_src1_ready;
  logic [DATA_WIDTH-1:0] disp_src1_value;
  logic [TAG_WIDTH-1:0]  disp_src1_tag;
  logic                  disp_src2_ready;
  logic [DATA_WIDTH-1:0] disp_src2_value;
  logic [TAG_WIDTH-1:0]  disp_src2_tag;

  logic                  cdb_valid;
  logic [DATA_WIDTH-1:0] cdb_value;
  logic [TAG_WIDTH-1:0]  cdb_tag;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [5:0]            issue_op;
  logic [TAG_WIDTH-1:0]  issue_tag;
  logic [4:0]            issue_dest_reg;
  logic [DATA_WIDTH-1:0] issue_src1;
  logic [DATA_WIDTH-1:0] issue_src2;

  logic [CNT_W-1:0]      free_count;

  modport master (
    output flush,
    output disp_valid, disp_op, disp_tag, disp_dest_reg,
    output disp_src1_ready, disp_src1_value, disp_src1_tag,
    output disp_src2_ready, disp_src2_value, disp_src2_tag,
    output cdb_valid, cdb_value, cdb_tag,
    output issue_ready,
    input  disp_ready, issue_valid, issue_op, issue_tag, issue_dest_reg,
    input  issue_src1, issue_src2, free_count
  );

  modport slave (
    input  flush,
    input  disp_valid, disp_op, disp_tag, disp_dest_reg,
    input  disp_src1_ready, disp_src1_value, disp_src1_tag,
    input  disp_src2_ready, disp_src2_value, disp_src2_tag,
    input  cdb_valid, cdb_value, cdb_tag,
    input  issue_ready,
    output disp_ready, issue_valid, issue_op, issue_tag, issue_dest_reg,
    output issue_src1, issue_src2, free_count
  );
endinterface

// File: rtl/cdb_reservation_station.sv
// rtl/cdb_reservation_station.sv - tag-matching reservation station with CDB wakeup
// Define RS_AGE_ORDER_EN for oldest-first issue; otherwise the lowest ready index issues.
module cdb_reservation_station #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  cdb_reservation_station_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef logic [IDX_W-1:0] idx_t;

  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DEPTH-1:0]      rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [5:0]            op_q    [DEPTH];
  logic [5:0]            op_d    [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q   [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_d   [DEPTH];
  logic [4:0]            dest_q  [DEPTH];
  logic [4:0]            dest_d  [DEPTH];
  logic [TAG_WIDTH-1:0]  ptag1_q [DEPTH];
  logic [TAG_WIDTH-1:0]  ptag1_d [DEPTH];
  logic [TAG_WIDTH-1:0]  ptag2_q [DEPTH];
  logic [TAG_WIDTH-1:0]  ptag2_d [DEPTH];
  logic [DATA_WIDTH-1:0] val1_q  [DEPTH];
  logic [DATA_WIDTH-1:0] val1_d  [DEPTH];
  logic [DATA_WIDTH-1:0] val2_q  [DEPTH];
  logic [DATA_WIDTH-1:0] val2_d  [DEPTH];

  logic [DEPTH-1:0] issuable;
  logic             disp_found, disp_fire;
  idx_t             disp_idx;
  logic             sel_found, issue_fire;
  idx_t             sel_idx;
  logic [CNT_W-1:0] free_cnt;

  // Only registered ready bits count, so a CDB broadcast never issues in its own cycle.
  assign issuable   = busy_q & rdy1_q & rdy2_q;
  assign disp_fire  = bus.disp_valid && disp_found;
  assign issue_fire = sel_found && bus.issue_ready;

  always_comb begin : find_free
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        disp_found = 1'b1;
        disp_idx   = idx_t'(i);
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // older_q[i][j] set means entry i was dispatched before entry j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_comb begin : age_block
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (issuable[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  always_comb begin : select_oldest
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (issuable[i] && !blocked[i]) begin
        sel_found = 1'b1;
        sel_idx   = idx_t'(i);
      end
    end
  end

  always_comb begin : age_next
    older_d = older_q;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end else begin
      if (issue_fire) begin
        older_d[sel_idx] = '0;
        for (int j = 0; j < DEPTH; j++) older_d[j][sel_idx] = 1'b0;
      end
      if (disp_fire) begin
        older_d[disp_idx] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          older_d[j][disp_idx] = busy_q[j] && !(issue_fire && sel_idx == idx_t'(j));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end
`else
  // A stalled issue keeps its entry selected so the outputs cannot switch under the consumer.
  logic hold_q, hold_d;
  idx_t hold_idx_q, hold_idx_d;

  always_comb begin : select_lowest
    sel_found = 1'b0;
    sel_idx   = '0;
    if (hold_q) begin
      sel_found = 1'b1;
      sel_idx   = hold_idx_q;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (issuable[i]) begin
          sel_found = 1'b1;
          sel_idx   = idx_t'(i);
        end
      end
    end
  end

  assign hold_d     = sel_found && !bus.issue_ready && !bus.flush;
  assign hold_idx_d = sel_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end
`endif

  always_comb begin : entry_next
    busy_d  = busy_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    op_d    = op_q;
    tag_d   = tag_q;
    dest_d  = dest_q;
    ptag1_d = ptag1_q;
    ptag2_d = ptag2_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (issue_fire) busy_d[sel_idx] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && bus.cdb_valid) begin
          if (!rdy1_q[i] && ptag1_q[i] == bus.cdb_tag) begin
            rdy1_d[i] = 1'b1;
            val1_d[i] = bus.cdb_value;
          end
          if (!rdy2_q[i] && ptag2_q[i] == bus.cdb_tag) begin
            rdy2_d[i] = 1'b1;
            val2_d[i] = bus.cdb_value;
          end
        end
      end
      if (disp_fire) begin
        busy_d[disp_idx]  = 1'b1;
        op_d[disp_idx]    = bus.disp_op;
        tag_d[disp_idx]   = bus.disp_tag;
        dest_d[disp_idx]  = bus.disp_dest_reg;
        ptag1_d[disp_idx] = bus.disp_src1_tag;
        ptag2_d[disp_idx] = bus.disp_src2_tag;
        rdy1_d[disp_idx]  = bus.disp_src1_ready;
        rdy2_d[disp_idx]  = bus.disp_src2_ready;
        val1_d[disp_idx]  = bus.disp_src1_value;
        val2_d[disp_idx]  = bus.disp_src2_value;
        // Result broadcast in the dispatch cycle would otherwise be missed forever.
        if (!bus.disp_src1_ready && bus.cdb_valid && bus.cdb_tag == bus.disp_src1_tag) begin
          rdy1_d[disp_idx] = 1'b1;
          val1_d[disp_idx] = bus.cdb_value;
        end
        if (!bus.disp_src2_ready && bus.cdb_valid && bus.cdb_tag == bus.disp_src2_tag) begin
          rdy2_d[disp_idx] = 1'b1;
          val2_d[disp_idx] = bus.cdb_value;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        tag_q[i]   <= '0;
        dest_q[i]  <= '0;
        ptag1_q[i] <= '0;
        ptag2_q[i] <= '0;
        val1_q[i]  <= '0;
        val2_q[i]  <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      dest_q  <= dest_d;
      ptag1_q <= ptag1_d;
      ptag2_q <= ptag2_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
    end
  end

  always_comb begin : count_free
    free_cnt = CNT_W'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) free_cnt = free_cnt - CNT_W'(1);
    end
  end

  assign bus.disp_ready  = disp_found;
  assign bus.issue_valid = sel_found;
  assign bus.free_count  = free_cnt;

  always_comb begin : issue_out
    bus.issue_op       = '0;
    bus.issue_tag      = '0;
    bus.issue_dest_reg = '0;
    bus.issue_src1     = '0;
    bus.issue_src2     = '0;
    if (sel_found) begin
      bus.issue_op       = op_q[sel_idx];
      bus.issue_tag      = tag_q[sel_idx];
      bus.issue_dest_reg = dest_q[sel_idx];
      bus.issue_src1     = val1_q[sel_idx];
      bus.issue_src2     = val2_q[sel_idx];
    end
  end
endmodule

// File: tb/tb_cdb_reservation_station.sv
// tb/tb_cdb_reservation_station.sv - directed table, corner sequences and random model check
// Honours RS_AGE_ORDER_EN the same way the design does.
module tb_cdb_reservation_station;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_reservation_station_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D)) rs_if ();

  cdb_reservation_station #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rs_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit r1; logic [DW-1:0] v1; logic [TW-1:0] t1;
    bit r2; logic [DW-1:0] v2; logic [TW-1:0] t2;
    bit c0v; logic [TW-1:0] c0t; logic [DW-1:0] c0d;
    bit c1v; logic [TW-1:0] c1t; logic [DW-1:0] c1d;
    bit ev1; bit ev2; logic [DW-1:0] es1; logic [DW-1:0] es2;
  } vec_t;
  vec_t vt[8];

  typedef struct {
    bit busy; logic [5:0] op; logic [TW-1:0] tag; logic [4:0] dest;
    bit r1; logic [DW-1:0] v1; logic [TW-1:0] t1;
    bit r2; logic [DW-1:0] v2; logic [TW-1:0] t2;
    int seq;
  } ent_t;
  ent_t m[D];
  int   seq_ctr;
  bit   held;
  int   held_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_if.flush = 0; rs_if.disp_valid = 0; rs_if.disp_op = '0; rs_if.disp_tag = '0;
    rs_if.disp_dest_reg = '0; rs_if.disp_src1_ready = 0; rs_if.disp_src1_value = '0;
    rs_if.disp_src1_tag = '0; rs_if.disp_src2_ready = 0; rs_if.disp_src2_value = '0;
    rs_if.disp_src2_tag = '0; rs_if.cdb_valid = 0; rs_if.cdb_value = '0; rs_if.cdb_tag = '0;
    rs_if.issue_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic [TW-1:0] tag, input logic [4:0] dest,
                          input bit r1, input logic [DW-1:0] v1, input logic [TW-1:0] t1,
                          input bit r2, input logic [DW-1:0] v2, input logic [TW-1:0] t2);
    rs_if.disp_valid = 1; rs_if.disp_op = op; rs_if.disp_tag = tag; rs_if.disp_dest_reg = dest;
    rs_if.disp_src1_ready = r1; rs_if.disp_src1_value = v1; rs_if.disp_src1_tag = t1;
    rs_if.disp_src2_ready = r2; rs_if.disp_src2_value = v2; rs_if.disp_src2_tag = t2;
  endtask

  task automatic set_cdb(input bit v, input logic [TW-1:0] t, input logic [DW-1:0] val);
    rs_if.cdb_valid = v; rs_if.cdb_tag = t; rs_if.cdb_value = val;
  endtask

  function automatic int model_sel();
    int s = -1;
`ifdef RS_AGE_ORDER_EN
    for (int i = 0; i < D; i++)
      if (m[i].busy && m[i].r1 && m[i].r2 && (s < 0 || m[i].seq < m[s].seq)) s = i;
`else
    if (held) return held_idx;
    for (int i = D - 1; i >= 0; i--)
      if (m[i].busy && m[i].r1 && m[i].r2) s = i;
`endif
    return s;
  endfunction

  function automatic int model_free_slot();
    for (int i = 0; i < D; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int model_free_count();
    int c = 0;
    for (int i = 0; i < D; i++) if (!m[i].busy) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) m[i] = '{default: 0};
    seq_ctr = 0; held = 0; held_idx = 0;
  endtask

  task automatic model_step(input int sel);
    int k;
    k = model_free_slot();
    if (rs_if.flush) begin
      for (int i = 0; i < D; i++) m[i].busy = 0;
      held = 0;
      return;
    end
    if (sel >= 0 && rs_if.issue_ready) m[sel].busy = 0;
    if (rs_if.cdb_valid) begin
      for (int i = 0; i < D; i++) begin
        if (m[i].busy && !m[i].r1 && m[i].t1 == rs_if.cdb_tag) begin m[i].r1 = 1; m[i].v1 = rs_if.cdb_value; end
        if (m[i].busy && !m[i].r2 && m[i].t2 == rs_if.cdb_tag) begin m[i].r2 = 1; m[i].v2 = rs_if.cdb_value; end
      end
    end
    if (rs_if.disp_valid && k >= 0) begin
      m[k].busy = 1; m[k].op = rs_if.disp_op; m[k].tag = rs_if.disp_tag; m[k].dest = rs_if.disp_dest_reg;
      m[k].r1 = rs_if.disp_src1_ready; m[k].v1 = rs_if.disp_src1_value; m[k].t1 = rs_if.disp_src1_tag;
      m[k].r2 = rs_if.disp_src2_ready; m[k].v2 = rs_if.disp_src2_value; m[k].t2 = rs_if.disp_src2_tag;
      if (!m[k].r1 && rs_if.cdb_valid && rs_if.cdb_tag == m[k].t1) begin m[k].r1 = 1; m[k].v1 = rs_if.cdb_value; end
      if (!m[k].r2 && rs_if.cdb_valid && rs_if.cdb_tag == m[k].t2) begin m[k].r2 = 1; m[k].v2 = rs_if.cdb_value; end
      m[k].seq = seq_ctr++;
    end
    held = (sel >= 0) && !rs_if.issue_ready;
    held_idx = sel;
  endtask

  logic [5:0] first_tag, second_tag;

  initial begin
    rst = 1'b1;
    idle();
    //            r1  v1     t1 r2  v2     t2 c0v c0t c0d      c1v c1t c1d        ev1 ev2 es1        es2
    vt[0] = '{1, 32'h10, 0, 1, 32'h20, 0, 0, 0, 32'h0,  0, 0, 32'h0,    1, 1, 32'h10,   32'h20};
    vt[1] = '{0, 32'h0,  3, 1, 32'h5,  0, 0, 0, 32'h0,  1, 3, 32'hDEAD,  0, 1, 32'hDEAD, 32'h5};
    vt[2] = '{1, 32'h1,  0, 0, 32'h0,  6, 1, 6, 32'h77, 0, 0, 32'h0,    1, 1, 32'h1,    32'h77};
    vt[3] = '{0, 32'h0,  4, 1, 32'h8,  0, 1, 5, 32'h11, 1, 2, 32'h22,   0, 0, 32'h0,    32'h0};
    vt[4] = '{0, 32'h0,  1, 0, 32'h0,  1, 0, 0, 32'h0,  1, 1, 32'hABCD, 0, 1, 32'hABCD, 32'hABCD};
    vt[5] = '{0, 32'h0,  2, 0, 32'h0,  3, 1, 2, 32'h99, 1, 3, 32'h42,   0, 1, 32'h99,   32'h42};
    vt[6] = '{0, 32'h0,  0, 1, 32'h3,  0, 0, 0, 32'h1234, 0, 0, 32'h5678, 0, 0, 32'h0,  32'h0};
    vt[7] = '{1, 32'h11, 3, 1, 32'h22, 3, 1, 3, 32'hFF, 1, 3, 32'hEE,   1, 1, 32'h11,   32'h22};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_free_count_async", rs_if.free_count, D);
    rst = 1'b0;
    chk("reset_disp_ready", rs_if.disp_ready, 1);
    chk("reset_issue_valid", rs_if.issue_valid, 0);
    chk("reset_issue_src1", rs_if.issue_src1, 0);
    chk("reset_issue_src2", rs_if.issue_src2, 0);
    chk("reset_issue_fields", {rs_if.issue_op, rs_if.issue_tag, rs_if.issue_dest_reg}, 0);

    for (int k = 0; k < 8; k++) begin
      idle(); do_reset();
      set_disp(6'd5, 3'd2, 5'd7, vt[k].r1, vt[k].v1, vt[k].t1, vt[k].r2, vt[k].v2, vt[k].t2);
      set_cdb(vt[k].c0v, vt[k].c0t, vt[k].c0d);
      tick();
      idle();
      set_cdb(vt[k].c1v, vt[k].c1t, vt[k].c1d);
      chk($sformatf("vec%0d_valid_after_disp", k), rs_if.issue_valid, vt[k].ev1);
      chk($sformatf("vec%0d_free_after_disp", k), rs_if.free_count, 3);
      tick();
      idle();
      chk($sformatf("vec%0d_valid_later", k), rs_if.issue_valid, vt[k].ev2);
      if (vt[k].ev2) begin
        chk($sformatf("vec%0d_src1", k), rs_if.issue_src1, vt[k].es1);
        chk($sformatf("vec%0d_src2", k), rs_if.issue_src2, vt[k].es2);
        chk($sformatf("vec%0d_op_tag_dest", k), {rs_if.issue_op, rs_if.issue_tag, rs_if.issue_dest_reg},
            {6'd5, 3'd2, 5'd7});
      end
      rs_if.issue_ready = 1;
      tick();
      idle();
      chk($sformatf("vec%0d_free_end", k), rs_if.free_count, vt[k].ev2 ? 4 : 3);
    end

    // Fill all entries, reject a fifth, then free one through wakeup + issue.
    idle(); do_reset();
    for (int i = 0; i < D; i++) begin
      set_disp(6'(i), 3'(i), 5'(i), 0, 32'h0, 3'(i + 1), 1, 32'h100 + i, 0);
      tick();
    end
    chk("full_disp_ready", rs_if.disp_ready, 0);
    chk("full_free_count", rs_if.free_count, 0);
    set_disp(6'd9, 3'd7, 5'd9, 1, 32'h9, 0, 1, 32'h9, 0);
    tick();
    idle();
    chk("full_fifth_ignored_free", rs_if.free_count, 0);
    chk("full_no_issue", rs_if.issue_valid, 0);
    set_cdb(1, 3'd3, 32'h33);
    tick();
    idle();
    chk("full_wake_valid", rs_if.issue_valid, 1);
    chk("full_wake_tag", rs_if.issue_tag, 2);
    chk("full_wake_src1", rs_if.issue_src1, 32'h33);
    chk("full_wake_src2", rs_if.issue_src2, 32'h102);
    rs_if.issue_ready = 1;
    tick();
    idle();
    chk("full_after_issue_ready", rs_if.disp_ready, 1);
    chk("full_after_issue_free", rs_if.free_count, 1);
    chk("full_after_issue_valid", rs_if.issue_valid, 0);

    // Age versus index order when two entries wake together.
    idle(); do_reset();
    set_disp(6'd1, 3'd1, 5'd1, 1, 32'hA1, 0, 1, 32'hA2, 0);
    tick();
    set_disp(6'd2, 3'd2, 5'd2, 0, 32'h0, 5, 1, 32'hB2, 0);
    tick();
    idle();
    chk("age_a_first", rs_if.issue_tag, 1);
    rs_if.issue_ready = 1;
    tick();
    idle();
    chk("age_after_a_free", rs_if.free_count, 3);
    set_disp(6'd3, 3'd3, 5'd3, 0, 32'h0, 5, 1, 32'hC2, 0);
    tick();
    idle();
    set_cdb(1, 3'd5, 32'h55);
    tick();
    idle();
`ifdef RS_AGE_ORDER_EN
    first_tag = 2; second_tag = 3;
`else
    first_tag = 3; second_tag = 2;
`endif
    chk("order_valid", rs_if.issue_valid, 1);
    chk("order_first_tag", rs_if.issue_tag, first_tag);
    chk("order_first_src1", rs_if.issue_src1, 32'h55);
    rs_if.issue_ready = 1;
    tick();
    chk("order_second_tag", rs_if.issue_tag, second_tag);
    tick();
    idle();
    chk("order_free_end", rs_if.free_count, 4);

    // Flush beats a simultaneous dispatch.
    idle(); do_reset();
    for (int i = 0; i < 3; i++) begin
      set_disp(6'd4, 3'(i), 5'd4, 0, 32'h0, 7, 0, 32'h0, 7);
      tick();
    end
    set_disp(6'd8, 3'd6, 5'd8, 1, 32'h8, 0, 1, 32'h8, 0);
    rs_if.flush = 1;
    chk("flush_pre_disp_ready", rs_if.disp_ready, 1);
    chk("flush_pre_free", rs_if.free_count, 1);
    tick();
    idle();
    chk("flush_free", rs_if.free_count, 4);
    chk("flush_issue_valid", rs_if.issue_valid, 0);
    set_cdb(1, 3'd7, 32'h7);
    tick();
    idle();
    tick();
    chk("flush_no_stale_wake", rs_if.issue_valid, 0);

    // Asynchronous reset mid-operation empties the station.
    set_disp(6'd1, 3'd1, 5'd1, 1, 32'h1, 0, 1, 32'h2, 0);
    tick();
    tick();
    idle();
    chk("midrst_before_free", rs_if.free_count, 2);
    rst = 1'b1;
    #2;
    chk("midrst_async_free", rs_if.free_count, 4);
    chk("midrst_async_valid", rs_if.issue_valid, 0);
    rst = 1'b0;
    tick();
    chk("midrst_after_ready", rs_if.disp_ready, 1);
    chk("midrst_after_free", rs_if.free_count, 4);

    // Random traffic against the behavioural model.
    idle(); do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      int sel;
      rs_if.flush           = ($urandom_range(39) == 0);
      rs_if.disp_valid      = ($urandom_range(99) < 60);
      rs_if.disp_op         = 6'($urandom);
      rs_if.disp_tag        = TW'($urandom);
      rs_if.disp_dest_reg   = 5'($urandom);
      rs_if.disp_src1_ready = ($urandom_range(99) < 40);
      rs_if.disp_src1_value = $urandom;
      rs_if.disp_src1_tag   = TW'($urandom);
      rs_if.disp_src2_ready = ($urandom_range(99) < 40);
      rs_if.disp_src2_value = $urandom;
      rs_if.disp_src2_tag   = TW'($urandom);
      rs_if.cdb_valid       = ($urandom_range(1) == 1);
      rs_if.cdb_value       = $urandom;
      rs_if.cdb_tag         = TW'($urandom);
      rs_if.issue_ready     = ($urandom_range(1) == 1);
      sel = model_sel();
      chk($sformatf("rnd%0d_disp_ready", n), rs_if.disp_ready, model_free_slot() >= 0);
      chk($sformatf("rnd%0d_free_count", n), rs_if.free_count, model_free_count());
      chk($sformatf("rnd%0d_issue_valid", n), rs_if.issue_valid, sel >= 0);
      if (sel >= 0) begin
        chk($sformatf("rnd%0d_fields", n), {rs_if.issue_op, rs_if.issue_tag, rs_if.issue_dest_reg},
            {m[sel].op, m[sel].tag, m[sel].dest});
        chk($sformatf("rnd%0d_src1", n), rs_if.issue_src1, m[sel].v1);
        chk($sformatf("rnd%0d_src2", n), rs_if.issue_src2, m[sel].v2);
      end else begin
        chk($sformatf("rnd%0d_idle_outputs", n),
            {rs_if.issue_op, rs_if.issue_tag, rs_if.issue_dest_reg, rs_if.issue_src1 | rs_if.issue_src2}, 0);
      end
      model_step(sel);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
